// File: rtl/rv32_lsu_pkg.sv
// Shared encodings for the RV32 load/store sequencer: funct3 codes, FSM states,
// fault causes and the accept-time legality checks.
package rv32_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_ILLEGAL  = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } fault_cause_e;

  // Unsigned-extension encodings only exist for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_st);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = is_st;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: store byte enables and lane replication,
// load right-shift and sign/zero extension.
module lsu_align
  import rv32_lsu_pkg::*;
(
  input  logic        acc_is_ld,
  input  logic [2:0]  acc_f3,
  input  logic [1:0]  acc_addr_lo,
  input  logic [31:0] acc_wdata,
  output logic [3:0]  acc_be,
  output logic [31:0] acc_wdata_lane,
  input  logic [2:0]  rsp_f3,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_load_val
);

  logic [31:0] shifted;

  always_comb begin
    acc_be         = 4'b1111;
    acc_wdata_lane = acc_wdata;
    if (!acc_is_ld) begin
      case (acc_f3[1:0])
        2'b00: begin
          acc_be         = 4'b0001 << acc_addr_lo;
          acc_wdata_lane = {4{acc_wdata[7:0]}};
        end
        2'b01: begin
          acc_be         = 4'b0011 << {acc_addr_lo[1], 1'b0};
          acc_wdata_lane = {2{acc_wdata[15:0]}};
        end
        default: begin
          acc_be         = 4'b1111;
          acc_wdata_lane = acc_wdata;
        end
      endcase
    end
  end

  always_comb begin
    shifted = rsp_rdata >> {rsp_addr_lo, 3'b000};
    case (rsp_f3)
      F3_B:    rsp_load_val = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rsp_load_val = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rsp_load_val = {24'h0, shifted[7:0]};
      F3_HU:   rsp_load_val = {16'h0, shifted[15:0]};
      default: rsp_load_val = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one access at a time, runs the memory
// req/ack handshake with a timeout, and drives writeback and fault reporting.
module lsu_ctrl
  import rv32_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_ld,
  input  logic        ex_st,
  input  logic [2:0]  ex_f3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_val,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 1);

  logic [1:0]  state_reg;
  logic [9:0]  cnt_reg;
  logic        ld_reg;
  logic [2:0]  f3_reg;
  logic [31:0] addr_reg;
  logic [4:0]  rd_reg;
  logic        mem_we_reg;
  logic [3:0]  mem_be_reg;
  logic [31:0] mem_wdata_reg;
  logic        wb_en_reg;
  logic [4:0]  wb_reg_reg;
  logic [31:0] wb_val_reg;
  logic        fault_reg;
  logic [1:0]  fault_cause_reg;
  logic [31:0] fault_addr_reg;

  logic        in_req;
  logic        accept;
  logic        acc_illegal;
  logic        acc_misal;
  logic        acc_legal;
  logic        acc_fault;
  logic        timeout_hit;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata_lane;
  logic [31:0] load_val;

  lsu_align u_align (
    .acc_is_ld      (ex_ld),
    .acc_f3         (ex_f3),
    .acc_addr_lo    (ex_addr[1:0]),
    .acc_wdata      (ex_wdata),
    .acc_be         (acc_be),
    .acc_wdata_lane (acc_wdata_lane),
    .rsp_f3         (f3_reg),
    .rsp_addr_lo    (addr_reg[1:0]),
    .rsp_rdata      (mem_rdata),
    .rsp_load_val   (load_val)
  );

  always_comb begin
    in_req      = (state_reg == ST_REQ);
    accept      = ex_valid & (ex_ld | ex_st) & ((state_reg == ST_IDLE) | (state_reg == ST_DONE));
    acc_illegal = f3_illegal(ex_f3, ~ex_ld);
    acc_misal   = f3_misaligned(ex_f3, ex_addr[1:0]);
    acc_fault   = accept & (acc_illegal | acc_misal);
    acc_legal   = accept & ~acc_illegal & ~acc_misal;
    timeout_hit = in_req & ~mem_ack & (cnt_reg == TO_LAST);
  end

  assign stall       = acc_legal | in_req;
  assign mem_req     = in_req;
  assign mem_addr    = in_req ? {addr_reg[31:2], 2'b00} : 32'h0;
  assign mem_we      = mem_we_reg;
  assign mem_be      = mem_be_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign wb_en       = wb_en_reg;
  assign wb_reg      = wb_reg_reg;
  assign wb_val      = wb_val_reg;
  assign fault       = fault_reg;
  assign fault_cause = fault_cause_reg;
  assign fault_addr  = fault_addr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      ld_reg          <= 1'b0;
      f3_reg          <= '0;
      addr_reg        <= '0;
      rd_reg          <= '0;
      mem_we_reg      <= 1'b0;
      mem_be_reg      <= '0;
      mem_wdata_reg   <= '0;
      wb_en_reg       <= 1'b0;
      wb_reg_reg      <= '0;
      wb_val_reg      <= '0;
      fault_reg       <= 1'b0;
      fault_cause_reg <= '0;
      fault_addr_reg  <= '0;
    end else begin
      fault_reg <= 1'b0;
      wb_en_reg <= 1'b0;
      if (state_reg == ST_REQ) begin
        // Ack wins over a timeout landing in the same cycle.
        if (mem_ack) begin
          state_reg     <= ST_DONE;
          wb_en_reg     <= ld_reg & (rd_reg != 5'd0);
          wb_reg_reg    <= rd_reg;
          wb_val_reg    <= load_val;
          mem_we_reg    <= 1'b0;
          mem_be_reg    <= '0;
          mem_wdata_reg <= '0;
        end else if (timeout_hit) begin
          state_reg       <= ST_IDLE;
          fault_reg       <= 1'b1;
          fault_cause_reg <= CAUSE_TIMEOUT;
          fault_addr_reg  <= addr_reg;
          mem_we_reg      <= 1'b0;
          mem_be_reg      <= '0;
          mem_wdata_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 10'd1;
        end
      end else begin
        state_reg <= ST_IDLE;
        if (acc_fault) begin
          fault_reg       <= 1'b1;
          fault_cause_reg <= acc_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
          fault_addr_reg  <= ex_addr;
        end else if (acc_legal) begin
          state_reg     <= ST_REQ;
          cnt_reg       <= '0;
          ld_reg        <= ex_ld;
          f3_reg        <= ex_f3;
          addr_reg      <= ex_addr;
          rd_reg        <= ex_rd;
          mem_we_reg    <= ~ex_ld;
          mem_be_reg    <= acc_be;
          mem_wdata_reg <= ex_ld ? 32'h0 : acc_wdata_lane;
        end
      end
    end
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the RV32 execute stage and the data memory port. It accepts one load or store at a time and runs a request/acknowledge handshake with the memory. It generates byte enables and store-lane steering, extracts and extends load data, and drives the writeback port. It stalls the pipeline while an access is in flight and reports misaligned, illegal or timed-out accesses.

## Interface
- TIMEOUT_CYC, 255: maximum cycles in REQ without `mem_ack` before a bus fault; range 1..1023.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute stage presents a valid instruction.
- ex_ld / ex_st  in  1 / 1  instruction is a load / store; `ex_ld` wins if both are high.
- ex_f3  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu (loads); 000/001/010 (stores).
- ex_addr  in  32  effective byte address.
- ex_wdata  in  32  store data; the relevant bytes are in the LSBs.
- ex_rd  in  5  load destination register.
- stall  out  1  freeze fetch/decode/execute.
- mem_req, mem_we  out  1, 1  request valid; write.
- mem_addr  out  32  word address, `{ex_addr[31:2],2'b00}`.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-steered store data.
- mem_rdata  in  32  read data, valid with `mem_ack`.
- mem_ack  in  1  access complete.
- wb_en, wb_reg, wb_val  out  1, 5, 32  register-file write port.
- fault  out  1  one-cycle fault pulse.
- fault_cause  out  2  01 misaligned, 10 illegal f3, 11 bus timeout.
- fault_addr  out  32  byte address of the faulting access.

## Operation
- FSM states: IDLE, REQ, DONE. Reset puts the FSM in IDLE and drives every output to 0.
- An access is accepted when `ex_valid & (ex_ld|ex_st)` in IDLE or DONE. At accept the block latches addr, f3, rd, the load/store flag and the steered wdata/be.
- Checks at accept:
  - Illegal f3: f3 ∈ {011,110,111}, and f3 ∈ {100,101} for stores. Cause 10.
  - Misaligned: halfword access with addr[0]=1, or word access with addr[1:0]≠0. Cause 01.
  - On either fault: no `mem_req`, `fault` pulses in the next cycle with cause and address, FSM goes to IDLE, no stall.
  - Illegal f3 takes precedence over misalignment.
- A legal access moves the FSM to REQ. In REQ:
  - `mem_req`=1 and addr/we/be/wdata stay stable until `mem_ack`.
  - On ack the FSM moves to DONE.
- Byte enables and store data:
  - sb: be=0001<<addr[1:0], wdata = byte replicated ×4.
  - sh: be=0011<<{addr[1],1'b0}, wdata = half replicated ×2.
  - sw: be=1111.
  - Loads drive be=1111 and we=0.
- Load data: shift `mem_rdata` right by addr[1:0]×8, then extend: 000 sign-byte, 001 sign-half, 010 word, 100 zero-byte, 101 zero-half.
- DONE lasts one cycle:
  - Loads: wb_en=1 with wb_reg=rd and the registered wb_val. wb_en=0 if rd=0.
  - Stores: no writeback.
  - A new access may be accepted in DONE (back-to-back).
- Timeout: a counter is cleared on entry to REQ and increments each REQ cycle without ack. When it reaches TIMEOUT_CYC, `mem_req` drops, `fault` pulses with cause 11, the FSM goes to IDLE and no writeback occurs.
- `mem_ack` outside REQ is ignored.
- `rst` mid-access: IDLE next cycle, `mem_req`=0, counter=0, pending writeback discarded.

## Timing
- `stall` = accept-of-legal-access | (state==REQ); it is combinational from the ex_* inputs and state.
- Accept at cycle N: `mem_req` high from N+1. An ack at N+k (k≥1) gives DONE and writeback at N+k+1, with `stall` low in that cycle.
- Zero-wait memory (ack in the first REQ cycle): 2-cycle load-to-writeback, stall high for 2 cycles.
- `fault` is registered: high exactly one cycle after the faulting accept, or one cycle after the timeout is reached.
- wb_en, wb_reg and wb_val are all registered, and wb_val is stable throughout the wb_en cycle.

## Structure
- Package `rv32_lsu_pkg`: f3 encoding constants, FSM state enum, fault-cause codes.
- Sub-module `lsu_align` (combinational): store lane steering and be generation, load shift and extend. `lsu_ctrl` holds the FSM, latches, timeout counter and output registers.

## Test plan
- lw at addr 0x100, rdata 0xDEADBEEF, ack in first REQ cycle -> mem_addr 0x100, be 1111, wb_en with wb_reg=rd and wb_val 0xDEADBEEF at N+2; stall high for 2 cycles.
- lb/lbu at addr 0x103, rdata 0x80FF_0000 -> wb_val 0xFFFFFF80 for lb and 0x00000080 for lbu.
- sh at addr 0x202, wdata 0x1234 -> be 1100, mem_wdata 0x12341234, we=1, no wb_en.
- lw at addr 0x101 -> no mem_req, fault=1 at N+1 with cause 01 and fault_addr 0x101; f3=011 -> cause 10.
- TIMEOUT_CYC=4 with no ack -> mem_req high for 4 cycles, then fault cause 11, stall low, no wb_en.
- rst asserted during REQ with ack in the same cycle -> state IDLE, all outputs 0 next cycle, no wb_en.
